// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack, EX-side valid/ready
// handoff, redirect input and the sticky fault flag.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] Ins;
    logic [31:0] nextPC;
    logic        pc_load;
    logic [31:0] newPC;
    logic        fault;

    modport master (
        output imem_req, imem_addr, ins_valid, Ins, nextPC, fault,
        input  imem_ack, imem_rdata, ins_ready, pc_load, newPC
    );

    modport slave (
        input  imem_req, imem_addr, ins_valid, Ins, nextPC, fault,
        output imem_ack, imem_rdata, ins_ready, pc_load, newPC
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one memory request per PC, hands the word to
// EX with valid/ready, honours redirects and latches a sticky fault on errors.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic       CLK,
    input  logic       RST,
    if_stage_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        pc_plus4 = pc + 32'd4;
    endfunction

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] ins_r, ins_s;
    logic [31:0] next_pc_r, next_pc_s;
    logic        valid_r, valid_s;
    logic        fault_r, fault_s;
    logic        pend_r, pend_s;
    logic [31:0] pend_pc_r, pend_pc_s;
    logic [7:0]  wait_r, wait_s;
    logic        req_r, req_s;
    logic        misaligned_s;

    assign misaligned_s = bus.pc_load && (bus.newPC[1:0] != 2'b00);

    // Next-state and datapath update for the fetch FSM
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        ins_s     = ins_r;
        next_pc_s = next_pc_r;
        valid_s   = valid_r;
        fault_s   = fault_r;
        pend_s    = pend_r;
        pend_pc_s = pend_pc_r;
        wait_s    = wait_r;

        if (state_r != ST_FAULT && misaligned_s) begin
            // A bad redirect target beats every other transition
            state_s = ST_FAULT;
            fault_s = 1'b1;
            valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.pc_load) begin
                        pc_s = bus.newPC;
                    end else begin
                        pc_s = pc_r;
                    end
                    wait_s  = 8'd0;
                    state_s = ST_REQ;
                end
                ST_REQ: begin
                    if (bus.imem_ack) begin
                        wait_s = 8'd0;
                        if (bus.pc_load) begin
                            pc_s   = bus.newPC;
                            pend_s = 1'b0;
                        end else if (pend_r) begin
                            // Word fetched from the stale path is dropped
                            pc_s   = pend_pc_r;
                            pend_s = 1'b0;
                        end else begin
                            ins_s     = bus.imem_rdata;
                            next_pc_s = pc_plus4(pc_r);
                            pc_s      = pc_plus4(pc_r);
                            valid_s   = 1'b1;
                            state_s   = ST_HOLD;
                        end
                    end else begin
                        if (bus.pc_load) begin
                            pend_s    = 1'b1;
                            pend_pc_s = bus.newPC;
                        end else begin
                            pend_s = pend_r;
                        end
                        if (wait_r >= WAIT_LAST) begin
                            fault_s = 1'b1;
                            valid_s = 1'b0;
                            state_s = ST_FAULT;
                        end else begin
                            wait_s = wait_r + 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.pc_load) begin
                        valid_s = 1'b0;
                        pc_s    = bus.newPC;
                        wait_s  = 8'd0;
                        state_s = ST_REQ;
                    end else if (bus.ins_ready) begin
                        valid_s = 1'b0;
                        wait_s  = 8'd0;
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_FAULT: begin
                    valid_s = 1'b0;
                    state_s = ST_FAULT;
                end
                default: begin
                    fault_s = 1'b1;
                    valid_s = 1'b0;
                    state_s = ST_FAULT;
                end
            endcase
        end

        req_s = (state_s == ST_REQ);
    end

    // State, datapath and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            ins_r     <= 32'h0000_0000;
            next_pc_r <= 32'h0000_0000;
            valid_r   <= 1'b0;
            fault_r   <= 1'b0;
            pend_r    <= 1'b0;
            pend_pc_r <= 32'h0000_0000;
            wait_r    <= 8'd0;
            req_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            ins_r     <= ins_s;
            next_pc_r <= next_pc_s;
            valid_r   <= valid_s;
            fault_r   <= fault_s;
            pend_r    <= pend_s;
            pend_pc_r <= pend_pc_s;
            wait_r    <= wait_s;
            req_r     <= req_s;
        end
    end

    assign bus.imem_req  = req_r;
    assign bus.imem_addr = pc_r;
    assign bus.ins_valid = valid_r;
    assign bus.Ins       = ins_r;
    assign bus.nextPC    = next_pc_r;
    assign bus.fault     = fault_r;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected fetch addresses and transfers are
// queued by the stimulus and consumed by a negedge monitor.
module tb_if_stage;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] addr_q[$];
    logic [31:0] ins_q[$];
    logic [31:0] npc_q[$];

    if_stage_if bus();

    if_stage #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic ack_fetch(input logic [31:0] data, input logic [31:0] exp_addr);
        addr_q.push_back(exp_addr);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        step();
        bus.imem_ack   = 1'b0;
    endtask

    // Monitor: every accepted request and every transfer is matched to the queues
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            if (bus.imem_req && bus.imem_ack) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got addr %h expected no request", bus.imem_addr);
                end else begin
                    check("ack_addr", bus.imem_addr, addr_q.pop_front());
                end
            end
            if (bus.ins_valid && bus.ins_ready && !bus.pc_load) begin
                if (ins_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got Ins %h expected no transfer", bus.Ins);
                end else begin
                    check("xfer_ins", bus.Ins, ins_q.pop_front());
                    check("xfer_npc", bus.nextPC, npc_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST            = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.ins_ready  = 1'b0;
        bus.pc_load    = 1'b0;
        bus.newPC      = 32'h0;
        #1 RST = 1'b0;
        #2;
        check("rst_req",   {31'd0, bus.imem_req},  32'd0);
        check("rst_addr",  bus.imem_addr,          32'h0);
        check("rst_valid", {31'd0, bus.ins_valid}, 32'd0);
        check("rst_ins",   bus.Ins,                32'h0);
        check("rst_npc",   bus.nextPC,             32'h0);
        check("rst_fault", {31'd0, bus.fault},     32'd0);
        @(posedge CLK);
        #1 RST = 1'b1;
        step();

        // First fetch and transfer
        check("t1_req",  {31'd0, bus.imem_req}, 32'd1);
        check("t1_addr", bus.imem_addr, 32'h0);
        bus.ins_ready = 1'b1;
        ins_q.push_back(32'h2008_0005); npc_q.push_back(32'h4);
        ack_fetch(32'h2008_0005, 32'h0);
        step();
        check("t1_next_addr", bus.imem_addr, 32'h4);

        // Back-pressure in HOLD
        bus.ins_ready = 1'b0;
        ins_q.push_back(32'h1111_1111); npc_q.push_back(32'h8);
        ack_fetch(32'h1111_1111, 32'h4);
        for (int i = 0; i < 5; i++) begin
            check("t2_valid", {31'd0, bus.ins_valid}, 32'd1);
            check("t2_ins",   bus.Ins, 32'h1111_1111);
            check("t2_npc",   bus.nextPC, 32'h8);
            check("t2_req",   {31'd0, bus.imem_req}, 32'd0);
            step();
        end
        bus.ins_ready = 1'b1;
        step();
        check("t2_next_addr", bus.imem_addr, 32'h8);

        // Redirect while stalled in REQ
        bus.pc_load = 1'b1; bus.newPC = 32'h40;
        step();
        bus.pc_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_addr_stable", bus.imem_addr, 32'h8);
            step();
        end
        ack_fetch(32'hDEAD_BEEF, 32'h8);
        check("t3_dropped", {31'd0, bus.ins_valid}, 32'd0);
        check("t3_new_addr", bus.imem_addr, 32'h40);

        // Redirect in HOLD squashes despite ins_ready
        bus.ins_ready = 1'b0;
        ack_fetch(32'h2222_2222, 32'h40);
        check("t4_valid", {31'd0, bus.ins_valid}, 32'd1);
        bus.pc_load = 1'b1; bus.newPC = 32'h100; bus.ins_ready = 1'b1;
        step();
        bus.pc_load = 1'b0;
        check("t4_squash", {31'd0, bus.ins_valid}, 32'd0);
        check("t4_addr", bus.imem_addr, 32'h100);

        // Redirect with ack in the same cycle, then wrap of PC+4
        bus.pc_load = 1'b1; bus.newPC = 32'hFFFF_FFFC;
        ack_fetch(32'h5555_5555, 32'h100);
        bus.pc_load = 1'b0;
        check("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
        check("t5_valid", {31'd0, bus.ins_valid}, 32'd0);
        ins_q.push_back(32'h3333_3333); npc_q.push_back(32'h0);
        ack_fetch(32'h3333_3333, 32'hFFFF_FFFC);
        check("t5_npc_wrap", bus.nextPC, 32'h0);
        step();
        check("t5_wrap_addr", bus.imem_addr, 32'h0);

        // Latest of several redirects wins
        bus.pc_load = 1'b1; bus.newPC = 32'h200;
        step();
        bus.newPC = 32'h300;
        step();
        bus.pc_load = 1'b0;
        step();
        ack_fetch(32'h6666_6666, 32'h0);
        check("t6_addr", bus.imem_addr, 32'h300);
        check("t6_valid", {31'd0, bus.ins_valid}, 32'd0);

        // Back-to-back fetches at two cycles per instruction
        for (int i = 0; i < 3; i++) begin
            ins_q.push_back(32'h7000_0000 + 32'(i));
            npc_q.push_back(32'h300 + 32'(4 * i) + 32'h4);
            ack_fetch(32'h7000_0000 + 32'(i), 32'h300 + 32'(4 * i));
            step();
        end
        check("t7_addr", bus.imem_addr, 32'h30C);

        // Timeout after 16 cycles without ack
        for (int i = 0; i < 15; i++) step();
        check("t8_no_fault_yet", {31'd0, bus.fault}, 32'd0);
        check("t8_req_yet", {31'd0, bus.imem_req}, 32'd1);
        step();
        check("t8_fault", {31'd0, bus.fault}, 32'd1);
        check("t8_req_off", {31'd0, bus.imem_req}, 32'd0);
        bus.pc_load = 1'b1; bus.newPC = 32'h104; bus.imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("t8_sticky", {31'd0, bus.fault}, 32'd1);
        check("t8_req_stays", {31'd0, bus.imem_req}, 32'd0);
        check("t8_valid_stays", {31'd0, bus.ins_valid}, 32'd0);
        bus.pc_load = 1'b0; bus.imem_ack = 1'b0;

        // Reset clears fault; a late ack seen in IDLE is ignored
        RST = 1'b0;
        #1;
        check("t9_rst_fault", {31'd0, bus.fault}, 32'd0);
        check("t9_rst_addr", bus.imem_addr, 32'h0);
        check("t9_rst_req", {31'd0, bus.imem_req}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h4444_4444;
        step();
        bus.imem_ack = 1'b0;
        check("t9_req", {31'd0, bus.imem_req}, 32'd1);
        check("t9_addr", bus.imem_addr, 32'h0);
        check("t9_valid", {31'd0, bus.ins_valid}, 32'd0);

        // Misaligned redirect faults at once
        bus.pc_load = 1'b1; bus.newPC = 32'h102;
        step();
        bus.pc_load = 1'b0;
        check("t10_fault", {31'd0, bus.fault}, 32'd1);
        check("t10_req", {31'd0, bus.imem_req}, 32'd0);

        step();
        check("addr_q_empty", 32'(addr_q.size()), 32'd0);
        check("xfer_q_empty", 32'(ins_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
